// File: rtl/vending_pkg.sv
// Shared definitions for the vending datapath: dispenser FSM encoding,
// coin-type indices, money width and a saturating counter helper.
package vending_pkg;

  localparam int MONEY_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_DONE   = 2'd3
  } disp_state_e;

  localparam logic [1:0] COIN0 = 2'd0;
  localparam logic [1:0] COIN1 = 2'd1;
  localparam logic [1:0] COIN2 = 2'd2;
  localparam logic [1:0] COIN3 = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'd255) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/coin_selector.sv
// Greedy coin choice: highest-index denomination that is in stock and
// does not exceed the remaining amount.
module coin_selector
  import vending_pkg::*;
#(
  parameter int STOCK_W = 8
) (
  input  logic [MONEY_W-1:0]          rem,
  input  logic [3:0][STOCK_W-1:0]     stock,
  input  logic [3:0][MONEY_W-1:0]     denom,
  output logic                        found,
  output logic [1:0]                  idx
);

  // Later (larger) indices override earlier ones, yielding the highest match.
  always_comb begin
    found = 1'b0;
    idx   = COIN0;
    for (int d = 0; d < 4; d++) begin
      if ((stock[d] != {STOCK_W{1'b0}}) && (denom[d] <= rem)) begin
        found = 1'b1;
        idx   = 2'(d);
      end else begin
        found = found;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time over a valid/ready handshake,
// tracking per-denomination stock and reporting any unpaid shortfall.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int DENOM0     = 5,
  parameter int DENOM1     = 10,
  parameter int DENOM2     = 20,
  parameter int DENOM3     = 50,
  parameter int STOCK_W    = 8,
  parameter int INIT_STOCK = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MONEY_W-1:0]  change_amount,
  input  logic                coin_ready,
  output logic                coin_valid,
  output logic [1:0]          coin_type,
  output logic                busy,
  output logic                done,
  output logic [MONEY_W-1:0]  shortfall,
  output logic [7:0]          coins_paid,
  input  logic                refill,
  input  logic [1:0]          refill_type,
  input  logic [STOCK_W-1:0]  refill_count,
  output logic [STOCK_W-1:0]  stock0,
  output logic [STOCK_W-1:0]  stock1,
  output logic [STOCK_W-1:0]  stock2,
  output logic [STOCK_W-1:0]  stock3
);

  localparam logic [STOCK_W-1:0] STOCK_ONE  = {{(STOCK_W-1){1'b0}}, 1'b1};
  localparam logic [STOCK_W-1:0] STOCK_FULL = {STOCK_W{1'b1}};
  localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);

  disp_state_e                state_q, state_d;
  logic [MONEY_W-1:0]         rem_q, rem_d;
  logic [3:0][STOCK_W-1:0]    stock_q, stock_d;
  logic [1:0]                 coin_type_q, coin_type_d;
  logic [MONEY_W-1:0]         shortfall_q, shortfall_d;
  logic [7:0]                 coins_paid_q, coins_paid_d;
  logic                       coin_valid_q, coin_valid_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [3:0][MONEY_W-1:0]    denom_s;
  logic                       found_s;
  logic [1:0]                 idx_s;
  logic [STOCK_W:0]           refill_sum_s;

  assign denom_s = {MONEY_W'(DENOM3), MONEY_W'(DENOM2), MONEY_W'(DENOM1), MONEY_W'(DENOM0)};

  coin_selector #(.STOCK_W(STOCK_W)) u_sel (
    .rem   (rem_q),
    .stock (stock_q),
    .denom (denom_s),
    .found (found_s),
    .idx   (idx_s)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    stock_d      = stock_q;
    coin_type_d  = coin_type_q;
    shortfall_d  = shortfall_q;
    coins_paid_d = coins_paid_q;
    refill_sum_s = {1'b0, stock_q[refill_type]} + {1'b0, refill_count};

    case (state_q)
      ST_IDLE: begin
        // Refill and start may coincide; both take effect on this edge.
        if (refill) begin
          stock_d[refill_type] = refill_sum_s[STOCK_W] ? STOCK_FULL : refill_sum_s[STOCK_W-1:0];
        end else begin
          stock_d = stock_q;
        end
        if (start) begin
          rem_d        = change_amount;
          coins_paid_d = 8'd0;
          shortfall_d  = {MONEY_W{1'b0}};
          state_d      = ST_SELECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SELECT: begin
        if (found_s) begin
          coin_type_d = idx_s;
          state_d     = ST_ISSUE;
        end else begin
          shortfall_d = rem_q;
          state_d     = ST_DONE;
        end
      end
      ST_ISSUE: begin
        if (coin_valid_q && coin_ready) begin
          rem_d                = rem_q - denom_s[coin_type_q];
          stock_d[coin_type_q] = stock_q[coin_type_q] - STOCK_ONE;
          coins_paid_d         = sat_inc8(coins_paid_q);
          state_d              = ST_SELECT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    coin_valid_d = (state_d == ST_ISSUE);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rem_q        <= {MONEY_W{1'b0}};
      stock_q      <= {4{STOCK_INIT}};
      coin_type_q  <= COIN0;
      shortfall_q  <= {MONEY_W{1'b0}};
      coins_paid_q <= 8'd0;
      coin_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      stock_q      <= stock_d;
      coin_type_q  <= coin_type_d;
      shortfall_q  <= shortfall_d;
      coins_paid_q <= coins_paid_d;
      coin_valid_q <= coin_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign coin_valid = coin_valid_q;
  assign coin_type  = coin_type_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign shortfall  = shortfall_q;
  assign coins_paid = coins_paid_q;
  assign stock0     = stock_q[0];
  assign stock1     = stock_q[1];
  assign stock2     = stock_q[2];
  assign stock3     = stock_q[3];

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Sequential back end of the vending datapath. It takes the 16-bit change amount computed by the price/discount/change path and pays it out one coin at a time to the coin-ejector mechanism over a valid/ready handshake. Payment is greedy and tracks on-hand coin stock per denomination. If stock or denominations cannot cover the full amount, it reports the shortfall that was not paid.

Parameters:
DENOM0, 5, value of coin type 0 (smallest)
DENOM1, 10, value of coin type 1
DENOM2, 20, value of coin type 2
DENOM3, 50, value of coin type 3 (largest); must satisfy DENOM3>DENOM2>DENOM1>DENOM0>0
STOCK_W, 8, width of each stock counter
INIT_STOCK, 20, stock of every type after reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to pay change_amount; honoured only in IDLE
change_amount  input  16  amount to pay, sampled on accepted start
coin_ready  input  1  ejector accepts current coin this cycle
coin_valid  output  1  coin request pending
coin_type  output  2  denomination index of pending coin
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when payout ends
shortfall  output  16  unpaid remainder; valid from done until next accepted start
coins_paid  output  8  coins ejected in current/last payout, saturating at 255
refill  input  1  add refill_count coins of refill_type; honoured only in IDLE
refill_type  input  2  denomination to refill
refill_count  input  STOCK_W  coins added
stock0..stock3  output  STOCK_W each  current stock per type

Behaviour:
- Reset (asynchronous, any state): state=IDLE; coin_valid=0, coin_type=0, busy=0, done=0, shortfall=0, coins_paid=0; all stocks=INIT_STOCK; rem=0. A reset during ISSUE drops the pending coin with no decrement.
- States: IDLE, SELECT, ISSUE, DONE.
- IDLE: on start, load rem<=change_amount, clear coins_paid and shortfall, then go to SELECT. start in any other state is ignored. If start and refill occur in the same IDLE cycle, perform both; the refill lands before the first SELECT.
- SELECT (1 cycle): choose the highest index d with stock[d]!=0 and DENOM[d]<=rem.
  - If rem==0 or no d qualifies: shortfall<=rem, then go to DONE.
  - Otherwise register coin_type<=d, then go to ISSUE.
- ISSUE: coin_valid=1, and coin_type is held stable until the handshake.
  - On coin_valid&coin_ready: rem-=DENOM[d]; stock[d]-=1; coins_paid+=1 (saturating); then go to SELECT.
  - No timeout. Backpressure of any length holds the state.
- DONE (1 cycle): done=1, then go to IDLE. shortfall and coins_paid are held.
- Latency: start at cycle N gives SELECT at N+1, first coin_valid at N+2, done at N+2 when nothing is payable. Each coin costs one SELECT cycle plus the handshake cycles (minimum 2 cycles/coin).
- Arithmetic: rem is 16-bit unsigned and never underflows, because selection guarantees DENOM<=rem.
- Stock: refill saturates at 2^STOCK_W-1. refill outside IDLE is ignored. Stock is never decremented below 0, because selection excludes empty types.

Decomposition:
- Shared package vending_pkg holds:
  - state encoding (IDLE=0, SELECT=1, ISSUE=2, DONE=3);
  - coin-type index constants;
  - the 16-bit money width, shared with the price/change path.
- Sub-module coin_selector: purely combinational.
  - Inputs: rem, the four stocks, the four denominations.
  - Outputs: found and idx.
- The FSM, rem, stock counters and handshake stay in change_dispenser.

Test Plan:
- Reset, then start with change_amount=85 and coin_ready always 1 -> coin_type sequence 3,2,2,1? No: greedy gives 50,20,10,5, i.e. coin_type 3,2,1,0. Expect shortfall=0, coins_paid=4, stocks 19/19/19/19, done exactly one pulse.
- change_amount=0 -> no coin_valid; done at start+2; shortfall=0; coins_paid=0.
- Refill type 3 with count 0 from IDLE after forcing stock3=0 via 20 payouts of 50, then change_amount=100 -> five type-2 coins; stock2 drops by 5; shortfall=0.
- change_amount=7 -> one type-0 coin; shortfall=2; done asserted.
- change_amount=50 with coin_ready low for 3 cycles after coin_valid rises -> coin_valid=1 and coin_type=3 stable across all 3 cycles. Exactly one decrement occurs, on the ready cycle.
- Reset asserted mid-ISSUE during payout of 85 -> outputs immediately at reset values; stocks return to 20. A start with 15 after reset pays type 1 then type 0.
- Refill type 0 with count 250 in IDLE -> stock0 saturates at 255. A refill pulse while busy -> no stock change.
